fp_unpack_stage: RTL
====================

Name: fp_unpack_stage

Overview:
- Registered pipeline stage directly downstream of the FP operand decoder.
- Consumes the decoded sign/exponent/mantissa of operands A and B plus the half/single mode flag.
- Produces, per operand: unbiased signed exponent, 24-bit significand with explicit hidden bit (half left-justified to single width), and a one-hot class vector.
- Valid/ready handshake with a 2-entry skid buffer, so downstream arithmetic (add/mul) sees one uniform format at full throughput.

Parameters:
- EXP_OUT_W, 10, width of signed unbiased exponent output (two's complement).
- SIG_W, 24, significand width including hidden bit.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  stage can accept operand pair.
- mode_fp  in  1  0 = half, 1 = single.
- sign_a, sign_b  in  1  decoded signs.
- exp_a, exp_b  in  8  decoded exponent fields (half: zero-extended 5-bit field).
- mant_a, mant_b  in  23  decoded mantissa fields (half: zero-extended 10-bit field).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_mode_fp  out  1  registered mode.
- out_sign_a, out_sign_b  out  1  registered signs.
- out_exp_a, out_exp_b  out  EXP_OUT_W  signed unbiased exponent.
- out_sig_a, out_sig_b  out  SIG_W  significand, hidden bit at [23].
- out_cls_a, out_cls_b  out  5  one-hot {snan, qnan, inf, sub, zero}; all-zero = normal.

Behaviour:
- Per-operand decode uses bias = 127 (single) or 15 (half), and exp_max = 255 (single) or 31 (half).
  - Half mantissa is left-justified: m24 = {mant[9:0], 13'b0}; single: m24 = mant[22:0].
- Classification:
  - exp == 0, m == 0 → zero; sig = 0; exp = 1 − bias.
  - exp == 0, m != 0 → sub; sig = {1'b0, m24}; exp = 1 − bias (single −126, half −14).
  - exp == exp_max, m == 0 → inf; sig = 0x800000; exp = exp_max − bias.
  - exp == exp_max, m != 0 → NaN. m24[22] = 1 → qnan, else snan. sig = {1'b1, m24}; exp = exp_max − bias.
  - Otherwise normal; sig = {1'b1, m24}; exp = exp − bias, sign-extended to EXP_OUT_W.
  - In half mode, exp bits [7:5] are ignored.
- Latency: exactly 1 cycle from an accepted input (in_valid && in_ready at edge N) to out_valid at N+1, provided the main register is free or draining.
- Handshake: a transfer occurs on an edge where valid && ready. out_* data stays stable while out_valid && !out_ready.
- Skid buffer: main register (drives outputs) plus one skid register.
  - Input accepted while main is valid and not draining → data goes to skid.
  - in_ready is registered: in_ready = !skid_valid (next-state).
  - When main drains and skid is valid, skid moves to main the same edge. Order is preserved and no pair is dropped or duplicated.
  - Simultaneous drain of main and accept of input with skid empty → new data loads directly into main.
  - Full (main + skid valid): in_ready = 0; in_valid is ignored.
- Reset while rst_n low:
  - out_valid = 0, skid_valid = 0, in_ready = 0; all data outputs = 0.
  - in_ready rises on the first edge after rst_n goes high.
  - Reset mid-transfer discards both entries without output.

Optional Feature:
- Macro FP_UNPACK_DAZ_EN (denormals-are-zero).
- When defined, subnormal operands are reported as zero: sig = 0, cls = zero, sign preserved, exp = 1 − bias.
- When undefined, subnormals are passed as specified above. The sub class bit can then be set only without the macro.

Decomposition:
- Package fp_unpack_pkg holds:
  - BIAS_SINGLE = 127, BIAS_HALF = 15, EXPMAX_SINGLE = 255, EXPMAX_HALF = 31.
  - EXP_OUT_W and SIG_W defaults.
  - Class bit indices CLS_ZERO = 0, CLS_SUB = 1, CLS_INF = 2, CLS_QNAN = 3, CLS_SNAN = 4.
  - A packed struct for the unpacked operand {sign, exp, sig, cls}.
- One combinational sub-module, fp_unpack_operand, instantiated twice (A and B). The top level holds the skid buffer and handshake.

Test Plan:
- Single 1.0 (exp 127, mant 0) on A, half 1.5 (exp 15, mant 0x200) on B, out_ready = 1 → next cycle out_exp_a = 0, out_sig_a = 0x800000, out_cls_a = 0; out_exp_b = 0, out_sig_b = 0xC00000.
- Half subnormal exp 0, mant 0x001 → out_exp = −14 (0x3F2), out_sig = 0x002000, cls = sub. With FP_UNPACK_DAZ_EN defined: sig = 0, cls = zero.
- Single exp 255: mant 0 → inf, sig 0x800000, exp 128. mant 0x400000 → qnan. mant 0x000001 → snan. Half exp 31, mant 0x200 → qnan, exp 16.
- out_ready = 0, three back-to-back inputs P0, P1, P2 → P0 in main, P1 in skid, in_ready = 0 the cycle after P1, P2 held. Release out_ready → outputs P0, P1, P2 in order on consecutive cycles, no gaps once streaming.
- Continuous in_valid = 1 and out_ready = 1 for 20 cycles → 20 outputs, in_ready stays 1, latency 1.
- rst_n pulled low with main and skid both full → out_valid = 0, in_ready = 0 during reset. in_ready = 1 one edge after release; no stale pair emitted.

Source files
------------

// File: rtl/fp_unpack_pkg.sv
// Shared types and constants for the FP unpack stage.
// Build option: define FP_UNPACK_DAZ_EN to flush subnormal operands to zero.
package fp_unpack_pkg;

    localparam int DEF_EXP_OUT_W = 32'd10;
    localparam int DEF_SIG_W     = 32'd24;

    localparam int BIAS_SINGLE   = 32'd127;
    localparam int BIAS_HALF     = 32'd15;
    localparam int EXPMAX_SINGLE = 32'd255;
    localparam int EXPMAX_HALF   = 32'd31;

    // Bit positions inside the one-hot class vector; all-zero means normal.
    localparam int CLS_ZERO = 32'd0;
    localparam int CLS_SUB  = 32'd1;
    localparam int CLS_INF  = 32'd2;
    localparam int CLS_QNAN = 32'd3;
    localparam int CLS_SNAN = 32'd4;

    typedef struct packed {
        logic                     sign;
        logic [DEF_EXP_OUT_W-1:0] exp;
        logic [DEF_SIG_W-1:0]     sig;
        logic [4:0]               cls;
    } unpacked_op_t;

    // One operand pair as held in the main or skid register.
    typedef struct packed {
        logic         mode_fp;
        unpacked_op_t a;
        unpacked_op_t b;
    } operand_pair_t;

endpackage

// File: rtl/fp_unpack_operand.sv
// Combinational unpack of one decoded operand into unbiased exponent,
// explicit-hidden-bit significand and one-hot class.
// Build option: FP_UNPACK_DAZ_EN reports subnormals as signed zero.
module fp_unpack_operand
    import fp_unpack_pkg::*;
(
    input  logic         mode_fp,
    input  logic         sign,
    input  logic [7:0]   exp_field,
    input  logic [22:0]  mant,
    output unpacked_op_t op
);

    localparam int EW = DEF_EXP_OUT_W;
    localparam logic [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] BIAS_S  = EW'(BIAS_SINGLE);
    localparam logic [EW-1:0] BIAS_H  = EW'(BIAS_HALF);
    localparam logic [7:0]    EMAX_S  = 8'(EXPMAX_SINGLE);
    localparam logic [7:0]    EMAX_H  = 8'(EXPMAX_HALF);

    logic [7:0]    exp_eff_s;
    logic [22:0]   m24_s;
    logic [7:0]    exp_max_s;
    logic [EW-1:0] bias_s;
    logic [EW-1:0] exp_ext_s;

    // Select format constants; half fields are narrowed and the mantissa left-justified.
    always_comb begin
        if (mode_fp) begin
            exp_eff_s = exp_field;
            m24_s     = mant;
            exp_max_s = EMAX_S;
            bias_s    = BIAS_S;
        end else begin
            exp_eff_s = {3'b000, exp_field[4:0]};
            m24_s     = {mant[9:0], 13'b0};
            exp_max_s = EMAX_H;
            bias_s    = BIAS_H;
        end
        exp_ext_s = {{(EW-8){1'b0}}, exp_eff_s};
    end

    // Classify the operand and build exponent/significand for its class.
    always_comb begin
        op.sign = sign;
        op.exp  = exp_ext_s - bias_s;
        op.sig  = '0;
        op.cls  = 5'b00000;
        if (exp_eff_s == 8'd0) begin
            // Zero and subnormal share the minimum normal exponent.
            op.exp = EXP_ONE - bias_s;
            if (m24_s == 23'd0) begin
                op.cls[CLS_ZERO] = 1'b1;
            end else begin
`ifdef FP_UNPACK_DAZ_EN
                op.cls[CLS_ZERO] = 1'b1;
`else
                op.sig           = {1'b0, m24_s};
                op.cls[CLS_SUB]  = 1'b1;
`endif
            end
        end else if (exp_eff_s == exp_max_s) begin
            op.sig = {1'b1, m24_s};
            if (m24_s == 23'd0) begin
                op.cls[CLS_INF] = 1'b1;
            end else if (m24_s[22]) begin
                op.cls[CLS_QNAN] = 1'b1;
            end else begin
                op.cls[CLS_SNAN] = 1'b1;
            end
        end else begin
            op.sig = {1'b1, m24_s};
        end
    end

endmodule

// File: rtl/fp_unpack_stage.sv
// Registered unpack stage: two operand unpackers feeding a main register
// plus one skid register behind a valid/ready handshake.
// Build option: FP_UNPACK_DAZ_EN (denormals-are-zero, handled in fp_unpack_operand).
module fp_unpack_stage
    import fp_unpack_pkg::*;
#(
    parameter int EXP_OUT_W = DEF_EXP_OUT_W,
    parameter int SIG_W     = DEF_SIG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode_fp,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [7:0]           exp_a,
    input  logic [7:0]           exp_b,
    input  logic [22:0]          mant_a,
    input  logic [22:0]          mant_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode_fp,
    output logic                 out_sign_a,
    output logic                 out_sign_b,
    output logic [EXP_OUT_W-1:0] out_exp_a,
    output logic [EXP_OUT_W-1:0] out_exp_b,
    output logic [SIG_W-1:0]     out_sig_a,
    output logic [SIG_W-1:0]     out_sig_b,
    output logic [4:0]           out_cls_a,
    output logic [4:0]           out_cls_b
);

    unpacked_op_t  op_a_s;
    unpacked_op_t  op_b_s;
    operand_pair_t in_pair_s;

    operand_pair_t main_r;
    operand_pair_t skid_r;
    logic          main_valid_r;
    logic          skid_valid_r;
    logic          in_ready_r;

    operand_pair_t main_nxt_s;
    operand_pair_t skid_nxt_s;
    logic          main_valid_nxt_s;
    logic          skid_valid_nxt_s;
    logic          accept_s;
    logic          drain_s;

    fp_unpack_operand u_op_a (
        .mode_fp   (mode_fp),
        .sign      (sign_a),
        .exp_field (exp_a),
        .mant      (mant_a),
        .op        (op_a_s)
    );

    fp_unpack_operand u_op_b (
        .mode_fp   (mode_fp),
        .sign      (sign_b),
        .exp_field (exp_b),
        .mant      (mant_b),
        .op        (op_b_s)
    );

    assign in_pair_s.mode_fp = mode_fp;
    assign in_pair_s.a       = op_a_s;
    assign in_pair_s.b       = op_b_s;

    // in_ready is low whenever the skid holds data, so an accept never meets a full skid.
    assign accept_s = in_valid && in_ready_r;
    assign drain_s  = main_valid_r && out_ready;

    // Next state of the main/skid pair; skid always refills main first to keep order.
    always_comb begin
        main_nxt_s       = main_r;
        skid_nxt_s       = skid_r;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (!main_valid_r || drain_s) begin
            if (skid_valid_r) begin
                main_nxt_s       = skid_r;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                main_nxt_s       = in_pair_s;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_nxt_s       = in_pair_s;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Pipeline registers; reset discards both entries and holds in_ready low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            main_r       <= main_nxt_s;
            skid_r       <= skid_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = main_valid_r;
    assign out_mode_fp = main_r.mode_fp;
    assign out_sign_a  = main_r.a.sign;
    assign out_sign_b  = main_r.b.sign;
    assign out_exp_a   = main_r.a.exp;
    assign out_exp_b   = main_r.b.exp;
    assign out_sig_a   = main_r.a.sig;
    assign out_sig_b   = main_r.b.sig;
    assign out_cls_a   = main_r.a.cls;
    assign out_cls_b   = main_r.b.cls;

endmodule
